alarm_ring_sequencer: RTL and testbench

- Owns the alarm set-point registers and the ring/snooze state machine for the digital clock.
- Consumes the single-cycle edit strobes from the alarm-mode control FSM (hour-inc, min-inc, on/off toggle) and the current time from the timekeeping counters.
- Decides when the alarm fires, sequences ringing, snooze and dismissal, and drives the buzzer and status outputs.

---
 rtl/alarm_ring_sequencer_if.sv | 29 ++
 rtl/alarm_ring_sequencer.sv | 152 +++++++++++++++
 tb/tb_alarm_ring_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ring_sequencer_if.sv
// Signal bundle between the alarm sequencer and the rest of the clock.
// The master drives strobes, buttons and the current time; the slave returns the alarm status.
interface alarm_ring_sequencer_if;
    logic       tick_1hz;
    logic       alm_hour;
    logic       alm_min;
    logic       alm_onoff;
    logic       sw_stop;
    logic       sw_snooze;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_en;
    logic       ringing;
    logic       buzzer;

    modport master (
        output tick_1hz, alm_hour, alm_min, alm_onoff,
        output sw_stop, sw_snooze, cur_hour, cur_min,
        input  alarm_hour, alarm_min, alarm_en, ringing, buzzer
    );

    modport slave (
        input  tick_1hz, alm_hour, alm_min, alm_onoff,
        input  sw_stop, sw_snooze, cur_hour, cur_min,
        output alarm_hour, alarm_min, alarm_en, ringing, buzzer
    );
endinterface

// File: rtl/alarm_ring_sequencer.sv
// Alarm set-point registers and ring/snooze sequencer for the digital clock.
// Define ALM_RING_TIMEOUT_EN to return to ARMED after RING_SEC ticks of unanswered ringing.
module alarm_ring_sequencer #(
    parameter int ALM_RST_HOUR = 7,
    parameter int ALM_RST_MIN  = 0,
    parameter int RING_SEC     = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input logic                   clk,
    input logic                   rst,
    alarm_ring_sequencer_if.slave bus
);

    typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZE} state_t;

    localparam int TMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [TW-1:0] SNZ_T = TW'(SNOOZE_SEC);
    localparam logic [TW-1:0] ONE_T = TW'(1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_SNOOZE);
`ifdef ALM_RING_TIMEOUT_EN
    localparam logic [TW-1:0] RING_T = TW'(RING_SEC);
`else
    localparam logic [TW-1:0] RING_T = '0;
`endif

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [CW-1:0] snz_cnt, snz_cnt_d;
    logic          beat, beat_d;
    logic [4:0]    hour_q;
    logic [5:0]    min_q;
    logic          match, match_q, fire;
    logic          stop_q, snz_q, stop_edge, snz_edge;
    logic          edit_ok;

    assign match     = (bus.cur_hour == hour_q) && (bus.cur_min == min_q);
    assign fire      = match & ~match_q;
    assign stop_edge = bus.sw_stop & ~stop_q;
    assign snz_edge  = bus.sw_snooze & ~snz_q;
    assign edit_ok   = (state != RINGING);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hour_q  <= 5'(ALM_RST_HOUR);
            min_q   <= 6'(ALM_RST_MIN);
            match_q <= 1'b0;
            stop_q  <= 1'b0;
            snz_q   <= 1'b0;
        end else begin
            match_q <= match;
            stop_q  <= bus.sw_stop;
            snz_q   <= bus.sw_snooze;
            if (edit_ok && bus.alm_min)
                min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (edit_ok && bus.alm_hour)
                hour_q <= (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DISARMED;
            timer   <= '0;
            snz_cnt <= '0;
            beat    <= 1'b0;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            snz_cnt <= snz_cnt_d;
            beat    <= beat_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        snz_cnt_d = snz_cnt;
        beat_d    = beat;
        unique case (state)
            DISARMED: begin
                if (bus.alm_onoff) state_d = ARMED;
            end
            ARMED: begin
                if (bus.alm_onoff) begin
                    state_d = DISARMED;
                end else if (fire) begin
                    state_d   = RINGING;
                    snz_cnt_d = '0;
                    timer_d   = RING_T;
                    beat_d    = 1'b1;
                end
            end
            RINGING: begin
                if (bus.alm_onoff) begin
                    state_d = DISARMED;
                end else if (stop_edge) begin
                    state_d   = ARMED;
                    snz_cnt_d = '0;
                end else if (snz_edge) begin
                    if (snz_cnt < MAX_C) begin
                        state_d   = SNOOZE;
                        timer_d   = SNZ_T;
                        snz_cnt_d = snz_cnt + 1'b1;
                    end else begin
                        state_d   = ARMED;
                        snz_cnt_d = '0;
                    end
                end else if (bus.tick_1hz) begin
                    beat_d = ~beat;
`ifdef ALM_RING_TIMEOUT_EN
                    if (timer == ONE_T) begin
                        state_d   = ARMED;
                        snz_cnt_d = '0;
                    end else if (timer != '0) begin
                        timer_d = timer - 1'b1;
                    end
`endif
                end
            end
            SNOOZE: begin
                if (bus.alm_onoff) begin
                    state_d = DISARMED;
                end else if (stop_edge) begin
                    state_d   = ARMED;
                    snz_cnt_d = '0;
                end else if (bus.tick_1hz) begin
                    if (timer == ONE_T) begin
                        state_d = RINGING;
                        timer_d = RING_T;
                        beat_d  = 1'b1;
                    end else if (timer != '0) begin
                        timer_d = timer - 1'b1;
                    end
                end
            end
            default: state_d = DISARMED;
        endcase
        // Idle states park the timer at zero so it can never wrap.
        if (state_d == ARMED || state_d == DISARMED) timer_d = '0;
    end

    assign bus.alarm_hour = hour_q;
    assign bus.alarm_min  = min_q;
    assign bus.alarm_en   = (state != DISARMED);
    assign bus.ringing    = (state == RINGING);
    assign bus.buzzer     = (state == RINGING) & beat;

endmodule

// File: tb/tb_alarm_ring_sequencer.sv
// Scoreboard bench for alarm_ring_sequencer: expectations queued at drive time, checked on negedge.
// Compile with ALM_RING_TIMEOUT_EN to exercise the ring timeout path (RING_SEC=4).
module tb_alarm_ring_sequencer;

    typedef struct {
        string       tag;
        logic [13:0] e;
        logic [13:0] m;
    } sb_t;

    localparam logic [13:0] MA = 14'h3fff;
    localparam logic [13:0] MS = 14'h0006;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];

    alarm_ring_sequencer_if ifc();

    alarm_ring_sequencer #(
        .ALM_RST_HOUR(7),
        .ALM_RST_MIN (0),
        .RING_SEC    (4),
        .SNOOZE_SEC  (300),
        .MAX_SNOOZE  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] pk(int h, int m, int en, int rg, int bz);
        return {h[4:0], m[5:0], en[0], rg[0], bz[0]};
    endfunction

    function automatic logic [13:0] obs();
        return {ifc.alarm_hour, ifc.alarm_min, ifc.alarm_en,
                ifc.ringing, ifc.buzzer};
    endfunction

    task automatic check(input string tag, input logic [13:0] got,
                         input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (hhhhh_mmmmmm_en_rg_bz)",
                     tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t s;
            s = sb.pop_front();
            check(s.tag, obs() & s.m, s.e & s.m);
        end
    end

    task automatic go(input string tag, input logic [13:0] e,
                      input logic [13:0] m);
        sb_t s;
        if (m != '0) begin
            s.tag = tag;
            s.e   = e;
            s.m   = m;
            sb.push_back(s);
        end
        @(negedge clk);
        #1;
        ifc.alm_hour  = 1'b0;
        ifc.alm_min   = 1'b0;
        ifc.alm_onoff = 1'b0;
        ifc.tick_1hz  = 1'b0;
    endtask

    task automatic snooze_wait(input int en_after, input int rg_after);
        for (int t = 1; t <= 300; t++) begin
            ifc.tick_1hz = 1'b1;
            if (t == 300)
                go("snz_end", pk(8, 3, en_after, rg_after, rg_after), MA);
            else
                go("snz_wait", pk(8, 3, 1, 0, 0), MS);
            go("", '0, '0);
        end
    endtask

    initial begin
        rst           = 1'b0;
        ifc.tick_1hz  = 1'b0;
        ifc.alm_hour  = 1'b0;
        ifc.alm_min   = 1'b0;
        ifc.alm_onoff = 1'b0;
        ifc.sw_stop   = 1'b0;
        ifc.sw_snooze = 1'b0;
        ifc.cur_hour  = 5'd12;
        ifc.cur_min   = 6'd30;
        #12;
        check("reset", obs(), pk(7, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        rst = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            ifc.alm_min = 1'b1;
            go("min_inc", pk(7, i, 0, 0, 0), MA);
        end
        ifc.alm_hour = 1'b1;
        go("hour_inc", pk(8, 3, 0, 0, 0), MA);

        for (int i = 4; i <= 59; i++) begin
            ifc.alm_min = 1'b1;
            go("min_59", pk(8, i, 0, 0, 0), (i == 59) ? MA : 14'h0);
        end
        ifc.alm_min = 1'b1;
        go("min_wrap", pk(8, 0, 0, 0, 0), MA);
        for (int h = 9; h <= 23; h++) begin
            ifc.alm_hour = 1'b1;
            go("hour_23", pk(h, 0, 0, 0, 0), (h == 23) ? MA : 14'h0);
        end
        ifc.alm_hour = 1'b1;
        go("hour_wrap", pk(0, 0, 0, 0, 0), MA);

        for (int h = 1; h <= 8; h++) begin
            ifc.alm_hour = 1'b1;
            go("", '0, '0);
        end
        for (int m = 1; m <= 3; m++) begin
            ifc.alm_min = 1'b1;
            go("restore", pk(8, m, 0, 0, 0), (m == 3) ? MA : 14'h0);
        end

        ifc.alm_onoff = 1'b1;
        ifc.cur_hour  = 5'd8;
        ifc.cur_min   = 6'd2;
        go("arm", pk(8, 3, 1, 0, 0), MA);
        go("armed_idle", pk(8, 3, 1, 0, 0), MA);
        ifc.cur_min = 6'd3;
        go("fire", pk(8, 3, 1, 1, 1), MA);

        for (int i = 0; i < 4; i++) begin
            ifc.tick_1hz = 1'b1;
            go("beat", pk(8, 3, 1, 1, (i % 2 == 0) ? 0 : 1), MA);
            go("beat_hold", pk(8, 3, 1, 1, (i % 2 == 0) ? 0 : 1), MA);
        end
        ifc.alm_min = 1'b1;
        go("edit_in_ring", pk(8, 3, 1, 1, 1), MA);

        ifc.sw_stop = 1'b1;
        go("stop", pk(8, 3, 1, 0, 0), MA);
        go("stop_held", pk(8, 3, 1, 0, 0), MA);
        go("no_refire", pk(8, 3, 1, 0, 0), MA);
        ifc.sw_stop = 1'b0;
        go("stop_rel", pk(8, 3, 1, 0, 0), MA);

        ifc.cur_min = 6'd4;
        go("", '0, '0);
        ifc.cur_min = 6'd3;
        go("refire", pk(8, 3, 1, 1, 1), MA);

        ifc.sw_snooze = 1'b1;
        go("snooze1", pk(8, 3, 1, 0, 0), MA);
        snooze_wait(1, 1);
        go("snz_held_once", pk(8, 3, 1, 1, 1), MA);
        ifc.sw_snooze = 1'b0;
        go("", '0, '0);

        for (int r = 2; r <= 3; r++) begin
            ifc.sw_snooze = 1'b1;
            go("snooze_n", pk(8, 3, 1, 0, 0), MA);
            ifc.sw_snooze = 1'b0;
            snooze_wait(1, 1);
        end

        ifc.sw_snooze = 1'b1;
        go("snooze_max", pk(8, 3, 1, 0, 0), MA);
        ifc.sw_snooze = 1'b0;
        snooze_wait(1, 0);

        ifc.cur_min = 6'd4;
        go("", '0, '0);
        ifc.cur_min = 6'd3;
        go("fire3", pk(8, 3, 1, 1, 1), MA);
        ifc.alm_onoff = 1'b1;
        ifc.sw_stop   = 1'b1;
        go("onoff_stop", pk(8, 3, 0, 0, 0), MA);
        ifc.sw_stop = 1'b0;
        go("disarmed", pk(8, 3, 0, 0, 0), MA);

        ifc.alm_onoff = 1'b1;
        ifc.cur_min   = 6'd4;
        go("rearm", pk(8, 3, 1, 0, 0), MA);
        ifc.cur_min = 6'd3;
        go("fire4", pk(8, 3, 1, 1, 1), MA);
        rst = 1'b0;
        #1;
        check("async_rst", obs(), pk(7, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        rst = 1'b1;

        ifc.cur_hour  = 5'd6;
        ifc.cur_min   = 6'd59;
        ifc.alm_onoff = 1'b1;
        go("arm2", pk(7, 0, 1, 0, 0), MA);
        ifc.cur_hour = 5'd7;
        ifc.cur_min  = 6'd0;
        go("fire5", pk(7, 0, 1, 1, 1), MA);
`ifdef ALM_RING_TIMEOUT_EN
        for (int t = 1; t <= 4; t++) begin
            ifc.tick_1hz = 1'b1;
            go("ring_tmo", pk(7, 0, 1, (t < 4) ? 1 : 0,
                              (t < 4 && t % 2 == 0) ? 1 : 0), MA);
            go("", '0, '0);
        end
        go("tmo_armed", pk(7, 0, 1, 0, 0), MA);
`else
        for (int t = 1; t <= 100; t++) begin
            ifc.tick_1hz = 1'b1;
            go("ring_hold", pk(7, 0, 1, 1, (t % 2 == 0) ? 1 : 0), MA);
            go("", '0, '0);
        end
        go("ring_100", pk(7, 0, 1, 1, 1), MA);
`endif

        check("sb_drain", 14'(sb.size()), 14'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
